// File: rtl/chanel_post_pkg.sv
// Shared helpers for the post-FFT averaging chain: width derivation,
// sample extension and the final round-and-shift of a completed block sum.
package chanel_post_pkg;

  // Working width for the helper functions; every accumulator fits inside it.
  localparam int MAX_W = 128;

  function automatic int calc_ch_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int calc_acc_w(input int width, input int log2_nmax);
    return width + log2_nmax;
  endfunction

  // Extend the low 'width' bits of data to MAX_W, sign- or zero-filling.
  function automatic logic [MAX_W-1:0] extend_sample(input logic [MAX_W-1:0] data,
                                                      input int width,
                                                      input bit is_signed);
    logic [MAX_W-1:0] r;
    logic             msb;
    msb = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i == width - 1) msb = data[i];
    end
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width) r[i] = data[i];
      else           r[i] = msb & is_signed;
    end
    return r;
  endfunction

  // Optional half-LSB bias followed by a right shift by k. The sum must
  // already be extended to MAX_W so the bias can never wrap.
  function automatic logic [MAX_W-1:0] round_shift(input logic [MAX_W-1:0] sum,
                                                    input int k,
                                                    input bit rnd,
                                                    input bit is_signed);
    logic [MAX_W-1:0]        r;
    logic signed [MAX_W-1:0] rs;
    r = sum;
    if (rnd && (k > 0)) r = sum + (MAX_W'(1) << (k - 1));
    if (is_signed) begin
      rs = r;
      rs = rs >>> k;
      r  = rs;
    end else begin
      r = r >> k;
    end
    return r;
  endfunction

endpackage

// File: rtl/chanel_accum_bank.sv
// Per-channel accumulator and sample-counter array with a single
// read-modify-write port addressed by the incoming channel index.
module chanel_accum_bank
  import chanel_post_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int LOG2_NMAX = 4,
  parameter int ACC_W     = 36,
  parameter int CH_W      = 2,
  parameter int K_W       = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             vld,
  input  logic [CH_W-1:0]  ch,
  input  logic [ACC_W-1:0] sample,
  input  logic [K_W-1:0]   k_act,
  output logic             done,
  output logic [CH_W-1:0]  done_ch,
  output logic [ACC_W-1:0] done_sum
);

  logic [ACC_W-1:0]     acc [CHANNELS];
  logic [LOG2_NMAX-1:0] cnt [CHANNELS];

  logic [ACC_W-1:0]     cur_acc;
  logic [LOG2_NMAX-1:0] cur_cnt;
  logic [LOG2_NMAX-1:0] limit;
  logic                 in_range;
  logic                 hit;
  logic                 last;
  logic [ACC_W-1:0]     sum_next;

  // Select the addressed channel's state and work out the updated sum.
  always_comb begin
    cur_acc  = '0;
    cur_cnt  = '0;
    in_range = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch == CH_W'(c)) begin
        cur_acc  = acc[c];
        cur_cnt  = cnt[c];
        in_range = 1'b1;
      end
    end
    limit    = LOG2_NMAX'(((LOG2_NMAX + 1)'(1) << k_act) - (LOG2_NMAX + 1)'(1));
    hit      = vld && !clr && in_range;
    last     = (cur_cnt == limit);
    sum_next = (cur_cnt == '0) ? sample : (cur_acc + sample);
  end

  assign done     = hit && last;
  assign done_ch  = ch;
  assign done_sum = sum_next;

  // Write back the addressed channel; reset or clear wipes every channel.
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc[c] <= '0;
        cnt[c] <= '0;
      end
    end else if (hit) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (ch == CH_W'(c)) begin
          acc[c] <= sum_next;
          cnt[c] <= last ? '0 : (cur_cnt + LOG2_NMAX'(1));
        end
      end
    end
  end

endmodule

// File: rtl/chanel_avg_decimator.sv
// Multi-channel block-averaging decimator: one averaged sample per channel
// every 2^k valid inputs, with run-time k, optional rounding and clear.
module chanel_avg_decimator
  import chanel_post_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CHANNELS  = 4,
  parameter int LOG2_NMAX = 4,
  parameter int SIGNED    = 0,
  localparam int CH_W     = calc_ch_w(CHANNELS),
  localparam int K_W      = $clog2(LOG2_NMAX + 1),
  localparam int ACC_W    = calc_acc_w(WIDTH, LOG2_NMAX)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_clr,
  input  logic [K_W-1:0]   cfg_log2n,
  input  logic             cfg_round,
  input  logic             i_vld,
  input  logic [CH_W-1:0]  i_ch,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_vld,
  output logic [CH_W-1:0]  o_ch,
  output logic [WIDTH-1:0] o_data,
  output logic             o_cfg_err
);

  localparam bit IS_SIGNED = (SIGNED != 0);

  logic             first_cyc;
  logic             load;
  logic [K_W-1:0]   k_act;
  logic             rnd_act;
  logic [ACC_W-1:0] sample_ext;
  logic             done;
  logic [CH_W-1:0]  done_ch;
  logic [ACC_W-1:0] done_sum;

  // Flag the first cycle after reset release so the config gets loaded then.
  always_ff @(posedge clk) begin
    if (!rstn) first_cyc <= 1'b1;
    else       first_cyc <= 1'b0;
  end

  assign load = i_clr || first_cyc;

  // Latch the active configuration, clamping an out-of-range length.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      k_act     <= '0;
      rnd_act   <= 1'b0;
      o_cfg_err <= 1'b0;
    end else if (load) begin
      rnd_act <= cfg_round;
      if (cfg_log2n > K_W'(LOG2_NMAX)) begin
        k_act     <= K_W'(LOG2_NMAX);
        o_cfg_err <= 1'b1;
      end else begin
        k_act     <= cfg_log2n;
        o_cfg_err <= 1'b0;
      end
    end
  end

  assign sample_ext = ACC_W'(extend_sample(MAX_W'(i_data), WIDTH, IS_SIGNED));

  chanel_accum_bank #(
    .CHANNELS  (CHANNELS),
    .LOG2_NMAX (LOG2_NMAX),
    .ACC_W     (ACC_W),
    .CH_W      (CH_W),
    .K_W       (K_W)
  ) u_bank (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (load),
    .vld      (i_vld),
    .ch       (i_ch),
    .sample   (sample_ext),
    .k_act    (k_act),
    .done     (done),
    .done_ch  (done_ch),
    .done_sum (done_sum)
  );

  // Register the averaged result of a completed block; hold between pulses.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_vld  <= 1'b0;
      o_ch   <= '0;
      o_data <= '0;
    end else begin
      o_vld <= done;
      if (done) begin
        o_ch   <= done_ch;
        o_data <= WIDTH'(round_shift(extend_sample(MAX_W'(done_sum), ACC_W, IS_SIGNED),
                                     int'(k_act), rnd_act, IS_SIGNED));
      end
    end
  end

endmodule

// File: tb/tb_chanel_avg_decimator.sv
// Directed self-checking bench for chanel_avg_decimator. Three instances:
// A unsigned 32-bit/4 channels, B signed 16-bit, C unsigned 8-bit/3 channels.
module tb_chanel_avg_decimator;

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH 32, CHANNELS 4, LOG2_NMAX 4, unsigned
  logic        a_rstn = 1'b0, a_clr = 1'b0, a_round = 1'b0, a_vld = 1'b0;
  logic [2:0]  a_cfg = '0;
  logic [1:0]  a_ch = '0;
  logic [31:0] a_data = '0;
  logic        a_ovld, a_err;
  logic [1:0]  a_och;
  logic [31:0] a_odata;

  chanel_avg_decimator #(.WIDTH(32), .CHANNELS(4), .LOG2_NMAX(4), .SIGNED(0)) dut_a (
    .clk(clk), .rstn(a_rstn), .i_clr(a_clr), .cfg_log2n(a_cfg), .cfg_round(a_round),
    .i_vld(a_vld), .i_ch(a_ch), .i_data(a_data),
    .o_vld(a_ovld), .o_ch(a_och), .o_data(a_odata), .o_cfg_err(a_err));

  // Instance B: WIDTH 16, CHANNELS 4, LOG2_NMAX 4, signed
  logic        b_rstn = 1'b0, b_clr = 1'b0, b_round = 1'b0, b_vld = 1'b0;
  logic [2:0]  b_cfg = '0;
  logic [1:0]  b_ch = '0;
  logic [15:0] b_data = '0;
  logic        b_ovld, b_err;
  logic [1:0]  b_och;
  logic [15:0] b_odata;

  chanel_avg_decimator #(.WIDTH(16), .CHANNELS(4), .LOG2_NMAX(4), .SIGNED(1)) dut_b (
    .clk(clk), .rstn(b_rstn), .i_clr(b_clr), .cfg_log2n(b_cfg), .cfg_round(b_round),
    .i_vld(b_vld), .i_ch(b_ch), .i_data(b_data),
    .o_vld(b_ovld), .o_ch(b_och), .o_data(b_odata), .o_cfg_err(b_err));

  // Instance C: WIDTH 8, CHANNELS 3, LOG2_NMAX 2, unsigned
  logic        c_rstn = 1'b0, c_clr = 1'b0, c_round = 1'b0, c_vld = 1'b0;
  logic [1:0]  c_cfg = '0;
  logic [1:0]  c_ch = '0;
  logic [7:0]  c_data = '0;
  logic        c_ovld, c_err;
  logic [1:0]  c_och;
  logic [7:0]  c_odata;

  chanel_avg_decimator #(.WIDTH(8), .CHANNELS(3), .LOG2_NMAX(2), .SIGNED(0)) dut_c (
    .clk(clk), .rstn(c_rstn), .i_clr(c_clr), .cfg_log2n(c_cfg), .cfg_round(c_round),
    .i_vld(c_vld), .i_ch(c_ch), .i_data(c_data),
    .o_vld(c_ovld), .o_ch(c_och), .o_data(c_odata), .o_cfg_err(c_err));

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_send(input logic vld, input logic [1:0] ch, input logic [31:0] data);
    a_vld = vld; a_ch = ch; a_data = data;
    step();
    a_vld = 1'b0;
  endtask

  task automatic b_send(input logic [1:0] ch, input logic [15:0] data);
    b_vld = 1'b1; b_ch = ch; b_data = data;
    step();
    b_vld = 1'b0;
  endtask

  task automatic c_send(input logic [1:0] ch, input logic [7:0] data);
    c_vld = 1'b1; c_ch = ch; c_data = data;
    step();
    c_vld = 1'b0;
  endtask

  task automatic test_reset();
    a_rstn = 1'b0; a_vld = 1'b1; a_ch = 2'd0; a_data = 32'h55;
    step(); step();
    a_vld = 1'b0;
    total++; if (a_ovld !== 1'b0) begin bad++; $display("[TB] FAIL reset_o_vld: got %b want 0", a_ovld); end
    total++; if (a_och !== 2'd0) begin bad++; $display("[TB] FAIL reset_o_ch: got %0d want 0", a_och); end
    total++; if (a_odata !== 32'd0) begin bad++; $display("[TB] FAIL reset_o_data: got %0h want 0", a_odata); end
    total++; if (a_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_o_cfg_err: got %b want 0", a_err); end
  endtask

  task automatic test_trunc_unsigned();
    logic [31:0] v [4] = '{32'd1, 32'd2, 32'd3, 32'd5};
    int early = 0;
    a_cfg = 3'd2; a_round = 1'b0;
    a_rstn = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      a_send(1'b1, 2'd0, v[i]);
      if (a_ovld !== 1'b0) early++;
    end
    total++; if (early != 0) begin bad++; $display("[TB] FAIL trunc_early_out: got %0d pulses want 0", early); end
    a_send(1'b1, 2'd0, v[3]);
    total++; if (a_ovld !== 1'b1) begin bad++; $display("[TB] FAIL trunc_o_vld: got %b want 1", a_ovld); end
    total++; if (a_och !== 2'd0) begin bad++; $display("[TB] FAIL trunc_o_ch: got %0d want 0", a_och); end
    total++; if (a_odata !== 32'd2) begin bad++; $display("[TB] FAIL trunc_o_data: got %0d want 2", a_odata); end
    early = 0;
    for (int i = 0; i < 3; i++) begin
      a_send(1'b1, 2'd0, 32'd7);
      if (a_ovld !== 1'b0) early++;
    end
    total++; if (early != 0) begin bad++; $display("[TB] FAIL trunc_partial_out: got %0d pulses want 0", early); end
    total++; if (a_odata !== 32'd2) begin bad++; $display("[TB] FAIL trunc_hold: got %0d want 2", a_odata); end
  endtask

  task automatic test_signed_round();
    logic [15:0] v [4] = '{16'hFFFF, 16'hFFFE, 16'hFFFE, 16'hFFFF};
    b_rstn = 1'b0; step();
    b_cfg = 3'd2; b_round = 1'b1; b_rstn = 1'b1;
    step();
    for (int i = 0; i < 4; i++) b_send(2'd1, v[i]);
    total++; if (b_ovld !== 1'b1) begin bad++; $display("[TB] FAIL sround_o_vld: got %b want 1", b_ovld); end
    total++; if (b_och !== 2'd1) begin bad++; $display("[TB] FAIL sround_o_ch: got %0d want 1", b_och); end
    total++; if (b_odata !== 16'hFFFF) begin bad++; $display("[TB] FAIL sround_o_data: got %0h want ffff", b_odata); end
    b_clr = 1'b1; b_round = 1'b0;
    step();
    b_clr = 1'b0;
    for (int i = 0; i < 4; i++) b_send(2'd1, v[i]);
    total++; if (b_ovld !== 1'b1) begin bad++; $display("[TB] FAIL strunc_o_vld: got %b want 1", b_ovld); end
    total++; if (b_odata !== 16'hFFFE) begin bad++; $display("[TB] FAIL strunc_o_data: got %0h want fffe", b_odata); end
  endtask

  task automatic test_interleave();
    a_clr = 1'b1; a_cfg = 3'd1; a_round = 1'b0;
    step();
    a_clr = 1'b0;
    for (int c = 0; c < 4; c++) begin
      a_vld = 1'b1; a_ch = 2'(c); a_data = 32'(10 * c);
      step();
      total++; if (a_ovld !== 1'b0) begin bad++; $display("[TB] FAIL ilv_first_ch%0d: got o_vld %b want 0", c, a_ovld); end
    end
    for (int c = 0; c < 4; c++) begin
      a_vld = 1'b1; a_ch = 2'(c); a_data = 32'(10 * c + 2);
      step();
      total++;
      if (a_ovld !== 1'b1 || a_och !== 2'(c) || a_odata !== 32'(10 * c + 1)) begin
        bad++;
        $display("[TB] FAIL ilv_out_ch%0d: got vld=%b ch=%0d data=%0d want vld=1 ch=%0d data=%0d",
                 c, a_ovld, a_och, a_odata, c, 10 * c + 1);
      end
    end
    a_vld = 1'b0;
    step();
    total++; if (a_ovld !== 1'b0) begin bad++; $display("[TB] FAIL ilv_pulse_len: got o_vld %b want 0", a_ovld); end
  endtask

  task automatic test_clr_drop();
    a_clr = 1'b1; a_cfg = 3'd3;
    step();
    a_clr = 1'b0;
    a_send(1'b1, 2'd0, 32'd100);
    a_send(1'b1, 2'd0, 32'd200);
    a_clr = 1'b1; a_cfg = 3'd0;
    a_send(1'b1, 2'd0, 32'd55);
    a_clr = 1'b0;
    total++; if (a_ovld !== 1'b0) begin bad++; $display("[TB] FAIL clr_drop: got o_vld %b want 0", a_ovld); end
    a_send(1'b1, 2'd0, 32'd77);
    total++;
    if (a_ovld !== 1'b1 || a_och !== 2'd0 || a_odata !== 32'd77) begin
      bad++; $display("[TB] FAIL echo_ch0: got vld=%b ch=%0d data=%0d want vld=1 ch=0 data=77", a_ovld, a_och, a_odata);
    end
    a_send(1'b1, 2'd2, 32'd9);
    total++;
    if (a_ovld !== 1'b1 || a_och !== 2'd2 || a_odata !== 32'd9) begin
      bad++; $display("[TB] FAIL echo_ch2: got vld=%b ch=%0d data=%0d want vld=1 ch=2 data=9", a_ovld, a_och, a_odata);
    end
  endtask

  task automatic test_cfg_err();
    int early = 0;
    a_clr = 1'b1; a_cfg = 3'd5; a_round = 1'b0;
    step();
    a_clr = 1'b0;
    total++; if (a_err !== 1'b1) begin bad++; $display("[TB] FAIL cfg_err_set: got %b want 1", a_err); end
    for (int i = 0; i < 15; i++) begin
      a_send(1'b1, 2'd3, 32'hFFFF_FFFF);
      if (a_ovld !== 1'b0) early++;
    end
    total++; if (early != 0) begin bad++; $display("[TB] FAIL clamp_early_out: got %0d pulses want 0", early); end
    a_send(1'b1, 2'd3, 32'hFFFF_FFFF);
    total++;
    if (a_ovld !== 1'b1 || a_och !== 2'd3 || a_odata !== 32'hFFFF_FFFF) begin
      bad++; $display("[TB] FAIL clamp_all_ones: got vld=%b ch=%0d data=%0h want vld=1 ch=3 data=ffffffff", a_ovld, a_och, a_odata);
    end
    a_clr = 1'b1; a_cfg = 3'd1;
    step();
    a_clr = 1'b0;
    total++; if (a_err !== 1'b0) begin bad++; $display("[TB] FAIL cfg_err_clear: got %b want 0", a_err); end
  endtask

  task automatic test_bad_channel_and_reset();
    logic [7:0] v [4] = '{8'd20, 8'd20, 8'd24, 8'd24};
    int early = 0;
    c_rstn = 1'b0; step();
    c_cfg = 2'd2; c_round = 1'b0; c_rstn = 1'b1;
    step();
    c_send(2'd0, 8'd4);
    c_send(2'd3, 8'd200);
    total++; if (c_ovld !== 1'b0) begin bad++; $display("[TB] FAIL badch_no_out: got o_vld %b want 0", c_ovld); end
    c_send(2'd0, 8'd8);
    c_send(2'd3, 8'd200);
    c_send(2'd0, 8'd12);
    c_send(2'd0, 8'd16);
    total++;
    if (c_ovld !== 1'b1 || c_och !== 2'd0 || c_odata !== 8'd10) begin
      bad++; $display("[TB] FAIL badch_avg: got vld=%b ch=%0d data=%0d want vld=1 ch=0 data=10", c_ovld, c_och, c_odata);
    end
    c_send(2'd0, 8'd100);
    c_send(2'd0, 8'd100);
    c_rstn = 1'b0;
    step();
    total++; if (c_ovld !== 1'b0 || c_odata !== 8'd0) begin bad++; $display("[TB] FAIL midrst_outputs: got vld=%b data=%0d want vld=0 data=0", c_ovld, c_odata); end
    c_rstn = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      c_send(2'd0, v[i]);
      if (c_ovld !== 1'b0) early++;
    end
    total++; if (early != 0) begin bad++; $display("[TB] FAIL midrst_stale_out: got %0d pulses want 0", early); end
    c_send(2'd0, v[3]);
    total++;
    if (c_ovld !== 1'b1 || c_odata !== 8'd22) begin
      bad++; $display("[TB] FAIL midrst_avg: got vld=%b data=%0d want vld=1 data=22", c_ovld, c_odata);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    $display("[TB] starting chanel_avg_decimator bench");
    test_reset();
    test_trunc_unsigned();
    test_signed_round();
    test_interleave();
    test_clr_drop();
    test_cfg_err();
    test_bad_channel_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chanel_avg_decimator.md
# chanel_avg_decimator

Multi-channel, time-multiplexed block-averaging decimator for the post-FFT processing chain. It keeps an independent accumulator and sample counter per channel. Every 2^k valid samples on a channel it emits one averaged sample tagged with that channel index, where k is a run-time setting. It generalises the single-channel fixed-length averager with per-channel state, run-time length, optional rounding, and a synchronous clear/reconfigure.

## Interface
Parameters:
- WIDTH, 32: sample width, input and output.
- CHANNELS, 4: number of interleaved channels (≥1).
- LOG2_NMAX, 4: largest supported log2 of the averaging length (≥1).
- SIGNED, 0: 0 = unsigned samples; 1 = two's-complement samples.
- Derived CH_W = max(1, $clog2(CHANNELS)); K_W = $clog2(LOG2_NMAX+1); ACC_W = WIDTH+LOG2_NMAX.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- i_clr  in  1  synchronous clear; loads the configuration.
- cfg_log2n  in  K_W  requested k (averaging length 2^k); sampled only on reset release or i_clr.
- cfg_round  in  1  1 = round to nearest; 0 = truncate. Sampled together with cfg_log2n.
- i_vld  in  1  input sample valid.
- i_ch  in  CH_W  channel of the input sample.
- i_data  in  WIDTH  input sample.
- o_vld  out  1  output sample valid, one-cycle pulse.
- o_ch  out  CH_W  channel of the output sample.
- o_data  out  WIDTH  averaged sample.
- o_cfg_err  out  1  sticky flag: cfg_log2n > LOG2_NMAX at the last load.

## Operation
- Active configuration registers k_act and rnd_act are loaded from cfg_log2n/cfg_round:
  - in the first cycle after reset release (rstn high), and
  - in every cycle with i_clr = 1.
- If cfg_log2n > LOG2_NMAX at a load: k_act = LOG2_NMAX and o_cfg_err = 1. A later legal load clears o_cfg_err.
- Per-channel state: acc[c] (ACC_W bits) and cnt[c] (LOG2_NMAX bits).
- On i_vld with i_ch < CHANNELS:
  - The sample is extended to ACC_W bits: sign-extended if SIGNED = 1, else zero-extended.
  - If cnt[c] == 0: acc[c] = extended sample. Otherwise acc[c] += extended sample.
  - If cnt[c] == 2^k_act − 1: the block completes. cnt[c] goes to 0 and output is produced. Otherwise cnt[c] increments.
- Samples with i_ch ≥ CHANNELS are dropped. No state changes and no output.
- Output computation on completion, with s = completed sum (including the current sample):
  - rnd_act = 1 and k_act > 0: r = s + 2^(k_act−1). Otherwise r = s.
  - o_data = r arithmetically right-shifted by k_act (SIGNED = 1) or logically shifted (SIGNED = 0), keeping the low WIDTH bits.
  - Signed rounding is round-half-up (toward +inf).
  - Overflow is impossible by construction; no saturation logic.
- k_act = 0: every valid sample is forwarded, registered, unchanged.
- i_clr has priority over i_vld: all cnt and acc are zeroed, a same-cycle sample is dropped, and no output is produced that cycle.
- Channels are fully independent. Arbitrary interleaving, including back-to-back samples on one channel, is legal at one sample per cycle.

## Timing
- Reset values: o_vld = 0, o_ch = 0, o_data = 0, o_cfg_err = 0. All cnt = 0 and all acc = 0.
- rstn low mid-block discards all partial sums. Reset release behaves as a fresh start.
- Latency: o_vld/o_ch/o_data are registered one cycle after the completing input sample.
- Throughput: one input per cycle. At most one output per cycle. There is no back-pressure; the consumer must accept every o_vld pulse.
- Between pulses o_data and o_ch hold their last value.
- Configuration load and i_clr take effect on the sample in the cycle after i_clr.

## Structure
- Package chanel_post_pkg holds:
  - ACC_W and CH_W helper functions;
  - the sign/zero extension function;
  - the round-and-shift function f(sum, k, rnd, signed).
- One sub-module, chanel_accum_bank: the per-channel acc/cnt register array with read-modify-write on i_ch.
- The top level holds the configuration registers, output stage, and error flag.

## Test plan
- Reset, then k = 2, trunc, unsigned, CH 0 samples 1, 2, 3, 5 → one o_vld, o_ch = 0, o_data = 2. Three further samples → no output.
- k = 2, round, SIGNED = 1, CH 1 samples −1, −2, −2, −1 → o_data = −1 (−6+2 = −4, >>2). Same with truncation → −2.
- k = 1, interleaved CH 0/1/2/3, values 10·ch and 10·ch+2 → four outputs, in completion order, values 10·ch+1, each one cycle after its second sample.
- After two samples of a k = 3 block, i_clr with cfg_log2n = 0 and a simultaneous i_vld → that sample dropped. Every later sample echoed 1 cycle later.
- cfg_log2n = LOG2_NMAX+1 at load → o_cfg_err = 1 and averaging over 2^LOG2_NMAX. All-ones unsigned inputs → o_data = 2^WIDTH−1, no wrap.
- i_ch = CHANNELS (with CHANNELS = 3): ignored. rstn pulse mid-block → next full block averages correctly from scratch.
